// File: rtl/ascon_fsm_ctrl.sv
// ascon_fsm_ctrl: Ascon-128 encryption sequencer driving round counter and permutation datapath controls
// Ports: clock_i/reset_i (sync active-high); start_i, data_valid_i, data_last_i handshake in;
// cpt_i round index in; cpt_en_o/cpt_init_12_o/cpt_init_6_o counter control; state_en_o, sel_init_o,
// xor_data_o, xor_key_begin_o, xor_key_end_o, xor_lsb_o datapath control; data_ready_o, cipher_valid_o,
// tag_valid_o, busy_o status.
module ascon_fsm_ctrl #(
  parameter int CPT_W      = 4,
  parameter int LAST_ROUND = 11
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             data_valid_i,
  input  logic             data_last_i,
  input  logic [CPT_W-1:0] cpt_i,
  output logic             cpt_en_o,
  output logic             cpt_init_12_o,
  output logic             cpt_init_6_o,
  output logic             state_en_o,
  output logic             sel_init_o,
  output logic             xor_data_o,
  output logic             xor_key_begin_o,
  output logic             xor_key_end_o,
  output logic             xor_lsb_o,
  output logic             data_ready_o,
  output logic             cipher_valid_o,
  output logic             tag_valid_o,
  output logic             busy_o
);
  typedef enum logic [2:0] {S_IDLE, S_INIT, S_WAIT_AD, S_AD, S_WAIT_PT, S_PT, S_FINAL, S_END} state_t;
  state_t r_state, w_next;
  logic   r_last;
  logic   w_c0, w_c6, w_cl;
  assign w_c0   = cpt_i == '0;
  assign w_c6   = cpt_i == CPT_W'(6);
  assign w_cl   = cpt_i == CPT_W'(LAST_ROUND);
  assign busy_o = r_state != S_IDLE;
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_state <= S_IDLE;
      r_last  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_WAIT_AD && data_valid_i) r_last <= data_last_i;
    end
  end
  always_comb begin
    w_next          = r_state;
    cpt_en_o        = 1'b0;
    cpt_init_12_o   = 1'b0;
    cpt_init_6_o    = 1'b0;
    state_en_o      = 1'b0;
    sel_init_o      = 1'b0;
    xor_data_o      = 1'b0;
    xor_key_begin_o = 1'b0;
    xor_key_end_o   = 1'b0;
    xor_lsb_o       = 1'b0;
    data_ready_o    = 1'b0;
    cipher_valid_o  = 1'b0;
    tag_valid_o     = 1'b0;
    unique case (r_state)
      S_IDLE: if (start_i) begin
        cpt_en_o      = 1'b1;
        cpt_init_12_o = 1'b1;
        w_next        = S_INIT;
      end
      S_INIT: begin
        state_en_o    = 1'b1;
        cpt_en_o      = 1'b1;
        sel_init_o    = w_c0;
        xor_key_end_o = w_cl;
        w_next        = w_cl ? S_WAIT_AD : S_INIT;
      end
      S_WAIT_AD: begin
        data_ready_o = 1'b1;
        cpt_en_o     = data_valid_i;
        cpt_init_6_o = data_valid_i;
        w_next       = data_valid_i ? S_AD : S_WAIT_AD;
      end
      S_AD: begin
        state_en_o = 1'b1;
        cpt_en_o   = 1'b1;
        xor_data_o = w_c6;
        xor_lsb_o  = w_cl && r_last;
        w_next     = !w_cl ? S_AD : r_last ? S_WAIT_PT : S_WAIT_AD;
      end
      S_WAIT_PT: begin
        // a last block skips the PT phase: its data goes in at the start of finalization
        data_ready_o  = 1'b1;
        cpt_en_o      = data_valid_i;
        cpt_init_6_o  = data_valid_i && !data_last_i;
        cpt_init_12_o = data_valid_i && data_last_i;
        w_next        = !data_valid_i ? S_WAIT_PT : data_last_i ? S_FINAL : S_PT;
      end
      S_PT: begin
        state_en_o     = 1'b1;
        cpt_en_o       = 1'b1;
        xor_data_o     = w_c6;
        cipher_valid_o = w_c6;
        w_next         = w_cl ? S_WAIT_PT : S_PT;
      end
      S_FINAL: begin
        state_en_o      = 1'b1;
        cpt_en_o        = 1'b1;
        xor_data_o      = w_c0;
        xor_key_begin_o = w_c0;
        cipher_valid_o  = w_c0;
        xor_key_end_o   = w_cl;
        w_next          = w_cl ? S_END : S_FINAL;
      end
      S_END: begin
        tag_valid_o = 1'b1;
        w_next      = S_IDLE;
      end
    endcase
  end
endmodule

// File: tb/tb_ascon_fsm_ctrl.sv
// tb_ascon_fsm_ctrl: table-driven check of the Ascon sequencer with a behavioural round counter
module tb_ascon_fsm_ctrl;
  localparam logic [12:0] CE = 13'h1000, I12 = 13'h0800, I6 = 13'h0400, SE = 13'h0200, SI = 13'h0100,
                          XD = 13'h0080, KB = 13'h0040, KE = 13'h0020, LSB = 13'h0010, RDY = 13'h0008,
                          CV = 13'h0004, TV = 13'h0002, BZ = 13'h0001;
  logic       clock_i = 0, reset_i = 1, start_i = 0, data_valid_i = 0, data_last_i = 0;
  logic [3:0] cpt_i = 0;
  logic       cpt_en_o, cpt_init_12_o, cpt_init_6_o, state_en_o, sel_init_o, xor_data_o, xor_key_begin_o;
  logic       xor_key_end_o, xor_lsb_o, data_ready_o, cipher_valid_o, tag_valid_o, busy_o;
  logic [12:0] w_out;
  int n_cmp = 0, n_bad = 0, n_tag = 0, n_lsb = 0;
  typedef struct {int n; logic s; logic v; logic l; logic [12:0] e; string nm;} vec_t;
  vec_t tbl[$];
  ascon_fsm_ctrl #(.CPT_W(4), .LAST_ROUND(11)) dut (
    .clock_i(clock_i), .reset_i(reset_i), .start_i(start_i), .data_valid_i(data_valid_i),
    .data_last_i(data_last_i), .cpt_i(cpt_i), .cpt_en_o(cpt_en_o), .cpt_init_12_o(cpt_init_12_o),
    .cpt_init_6_o(cpt_init_6_o), .state_en_o(state_en_o), .sel_init_o(sel_init_o),
    .xor_data_o(xor_data_o), .xor_key_begin_o(xor_key_begin_o), .xor_key_end_o(xor_key_end_o),
    .xor_lsb_o(xor_lsb_o), .data_ready_o(data_ready_o), .cipher_valid_o(cipher_valid_o),
    .tag_valid_o(tag_valid_o), .busy_o(busy_o)
  );
  assign w_out = {cpt_en_o, cpt_init_12_o, cpt_init_6_o, state_en_o, sel_init_o, xor_data_o, xor_key_begin_o,
                  xor_key_end_o, xor_lsb_o, data_ready_o, cipher_valid_o, tag_valid_o, busy_o};
  always #5 clock_i = ~clock_i;
  always @(posedge clock_i)
    if (reset_i) cpt_i <= 0;
    else if (cpt_en_o) cpt_i <= cpt_init_12_o ? 4'd0 : cpt_init_6_o ? 4'd6 : cpt_i + 4'd1;
  always @(negedge clock_i) begin
    if (tag_valid_o) n_tag++;
    if (xor_lsb_o) n_lsb++;
  end
  task automatic add(input int n, input logic s, input logic v, input logic l, input logic [12:0] e, input string nm);
    tbl.push_back('{n, s, v, l, e, nm});
  endtask
  task automatic check(input string nm, input int k, input logic [12:0] e);
    n_cmp++;
    if (w_out !== e) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %h want %h", nm, k, w_out, e);
    end
  endtask
  task automatic run(input int lo, input int hi);
    for (int i = lo; i <= hi; i++)
      for (int k = 0; k < tbl[i].n; k++) begin
        start_i = tbl[i].s; data_valid_i = tbl[i].v; data_last_i = tbl[i].l;
        @(negedge clock_i);
        check(tbl[i].nm, k, tbl[i].e);
        @(posedge clock_i); #1;
      end
  endtask
  task automatic check_cnt(input string nm, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask
  initial begin
    add(2,  0, 0, 0, 13'h0,             "idle");
    add(1,  1, 0, 0, CE|I12,            "start");
    add(1,  0, 0, 0, SE|CE|SI|BZ,       "init0");
    add(10, 0, 0, 0, SE|CE|BZ,          "init1_10");
    add(1,  0, 0, 0, SE|CE|KE|BZ,       "init11");
    add(2,  0, 0, 0, RDY|BZ,            "wad_idle");
    add(1,  0, 1, 0, CE|I6|RDY|BZ,      "wad_acc");
    add(1,  0, 0, 0, SE|CE|XD|BZ,       "ad6");
    add(4,  0, 0, 0, SE|CE|BZ,          "ad7_10");
    add(1,  0, 0, 0, SE|CE|BZ,          "ad11");
    add(1,  0, 1, 1, CE|I6|RDY|BZ,      "wad_last");
    add(1,  0, 0, 0, SE|CE|XD|BZ,       "ad6b");
    add(4,  0, 0, 0, SE|CE|BZ,          "ad7_10b");
    add(1,  0, 0, 0, SE|CE|LSB|BZ,      "ad11_lsb");
    add(1,  0, 0, 0, RDY|BZ,            "wpt_idle");
    add(1,  0, 1, 0, CE|I6|RDY|BZ,      "wpt_acc");
    add(1,  0, 0, 0, SE|CE|XD|CV|BZ,    "pt6");
    add(5,  0, 0, 0, SE|CE|BZ,          "pt7_11");
    add(1,  0, 1, 1, CE|I12|RDY|BZ,     "wpt_last");
    add(1,  0, 0, 0, SE|CE|XD|KB|CV|BZ, "fin0");
    add(10, 0, 0, 0, SE|CE|BZ,          "fin1_10");
    add(1,  0, 0, 0, SE|CE|KE|BZ,       "fin11");
    add(1,  0, 0, 0, TV|BZ,             "end");
    add(1,  0, 0, 0, 13'h0,             "idle_after");
    add(1,  1, 1, 1, CE|I12,            "ab_start");
    add(1,  1, 1, 1, SE|CE|SI|BZ,       "ab_init0");
    add(10, 1, 1, 1, SE|CE|BZ,          "ab_init1_10");
    add(1,  1, 1, 1, SE|CE|KE|BZ,       "ab_init11");
    add(1,  1, 1, 1, CE|I6|RDY|BZ,      "ab_wad_last");
    add(1,  1, 1, 0, SE|CE|XD|BZ,       "ab_ad6");
    add(4,  1, 1, 0, SE|CE|BZ,          "ab_ad7_10");
    add(1,  1, 1, 0, SE|CE|LSB|BZ,      "ab_ad11");
    add(1,  1, 1, 1, CE|I12|RDY|BZ,     "ab_wpt_last");
    add(1,  1, 1, 0, SE|CE|XD|KB|CV|BZ, "ab_fin0");
    add(10, 1, 1, 1, SE|CE|BZ,          "ab_fin1_10");
    add(1,  1, 1, 1, SE|CE|KE|BZ,       "ab_fin11");
    add(1,  1, 1, 1, TV|BZ,             "ab_end");
    add(2,  0, 1, 1, 13'h0,             "ab_idle");
    add(1,  0, 0, 0, SE|CE|BZ,          "mid_ad7");
    reset_i = 1;
    repeat (2) @(posedge clock_i);
    #1 reset_i = 0;
    run(0, 23);
    check_cnt("tag_run1", n_tag, 1);
    run(24, 37);
    check_cnt("tag_run2", n_tag, 2);
    run(24, 29);
    run(38, 38);
    start_i = 0; data_valid_i = 0; data_last_i = 0; reset_i = 1;
    @(negedge clock_i);
    check("mid_ad8_rst", 0, SE|CE|BZ);
    @(posedge clock_i); #1;
    reset_i = 0;
    run(0, 0);
    check_cnt("lsb_after_abort", n_lsb, 2);
    check_cnt("tag_after_abort", n_tag, 2);
    run(24, 37);
    check_cnt("lsb_total", n_lsb, 3);
    check_cnt("tag_total", n_tag, 3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
